// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state type and constants for inst_loader.
// S_CSUM exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  localparam int BYTE_CNT_W = 2;

  localparam logic [7:0] ACK_OK  = 8'hAA;
  localparam logic [7:0] ACK_ERR = 8'hEE;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_ACK,
    S_DONE,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - packs a byte stream into big-endian 32-bit words.
// word/word_valid are combinational on the 4th byte so the caller can register the result.
module loader_word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [23:0]           shreg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (in_valid) begin
      byte_cnt <= byte_cnt + 1'b1;
      shreg    <= {shreg[15:0], in_data};
    end
  end

  assign word       = {shreg, in_data};
  assign word_valid = in_valid && (byte_cnt == '1);

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - boot loader: UART byte image -> instruction BRAM, then releases core reset.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module inst_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              inst_we,
  output logic [ADDR_W-1:0] inst_waddr,
  output logic [31:0]       inst_wdata,
  output logic              core_rstn,
  output logic              load_error
);

  localparam logic [32:0]     MAX_WORDS = 33'd1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_t   state;
  logic [ADDR_W:0] n_words;
  logic [ADDR_W:0] word_cnt;

  logic [31:0] len_word;
  logic        len_word_valid;
  logic [31:0] data_word;
  logic        data_word_valid;

  // Separate assemblers keep the length field and data stream byte counters independent.
  loader_word_assembler u_len_asm (
    .clk        (clk),
    .rstn       (rstn),
    .in_data    (rx_data),
    .in_valid   (rx_valid && state == S_LEN),
    .word       (len_word),
    .word_valid (len_word_valid)
  );

  loader_word_assembler u_data_asm (
    .clk        (clk),
    .rstn       (rstn),
    .in_data    (rx_data),
    .in_valid   (rx_valid && state == S_DATA),
    .word       (data_word),
    .word_valid (data_word_valid)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_LEN;
      n_words    <= '0;
      word_cnt   <= '0;
      inst_we    <= 1'b0;
      inst_waddr <= '0;
      inst_wdata <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      core_rstn  <= 1'b0;
      load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      inst_we <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      if (rx_valid && (state == S_LEN || state == S_DATA))
        csum <= csum ^ rx_data;
`endif
      case (state)
        S_LEN: begin
          if (len_word_valid) begin
            if ({1'b0, len_word} > MAX_WORDS) begin
              state      <= S_ERR;
              tx_valid   <= 1'b1;
              tx_data    <= ACK_ERR;
              load_error <= 1'b1;
            end else begin
              n_words <= len_word[ADDR_W:0];
              if (len_word == '0) begin
`ifdef LOADER_CHECKSUM_EN
                state <= S_CSUM;
`else
                state    <= S_ACK;
                tx_valid <= 1'b1;
                tx_data  <= ACK_OK;
`endif
              end else begin
                state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (data_word_valid) begin
            inst_we    <= 1'b1;
            inst_waddr <= word_cnt[ADDR_W-1:0];
            inst_wdata <= data_word;
            word_cnt   <= word_cnt + ONE;
            if (word_cnt == n_words - ONE) begin
`ifdef LOADER_CHECKSUM_EN
              state <= S_CSUM;
`else
              state    <= S_ACK;
              tx_valid <= 1'b1;
              tx_data  <= ACK_OK;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (rx_valid) begin
            tx_valid <= 1'b1;
            if (rx_data == csum) begin
              state   <= S_ACK;
              tx_data <= ACK_OK;
            end else begin
              state      <= S_ERR;
              tx_data    <= ACK_ERR;
              load_error <= 1'b1;
            end
          end
        end
`endif
        S_ACK: begin
          if (tx_ready) begin
            tx_valid  <= 1'b0;
            core_rstn <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_ERR: begin
          if (tx_ready)
            tx_valid <= 1'b0;
        end
        S_DONE: ;
        default: state <= S_LEN;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - randomized directed bench for inst_loader with a queue-based image model.
// Honors LOADER_CHECKSUM_EN the same way as the design.
module tb_inst_loader;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rstn;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          inst_we;
  logic [AW-1:0] inst_waddr;
  logic [31:0]   inst_wdata;
  logic          core_rstn;
  logic          load_error;

  inst_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .inst_we    (inst_we),
    .inst_waddr (inst_waddr),
    .inst_wdata (inst_wdata),
    .core_rstn  (core_rstn),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic [7:0]       img[$];
  logic [AW+31:0]   got[$];
  logic [AW+31:0]   exp_wr[$];
  logic [31:0]      ws[$];

  always @(negedge clk)
    if (rstn && inst_we) got.push_back({inst_waddr, inst_wdata});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic do_reset();
    rstn = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    got.delete();
  endtask

  // Image = 4 length bytes MSB first, words MSB first, optional XOR of every preceding byte.
  task automatic build(input logic [31:0] n, input bit bad_csum);
    logic [7:0] x;
    img.delete();
    for (int b = 3; b >= 0; b--) img.push_back(n[8*b +: 8]);
    foreach (ws[i]) for (int b = 3; b >= 0; b--) img.push_back(ws[i][8*b +: 8]);
`ifdef LOADER_CHECKSUM_EN
    x = 8'h00;
    foreach (img[i]) x ^= img[i];
    img.push_back(bad_csum ? ~x : x);
`else
    x = {7'd0, bad_csum};
`endif
  endtask

  task automatic send(input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      rx_data = img[i]; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic run_image(input string tag, input logic [31:0] n, input bit bad_csum,
                           input bit gaps, input int hold);
    bit exp_err;
    bit csum_err;
`ifdef LOADER_CHECKSUM_EN
    csum_err = bad_csum;
`else
    csum_err = 1'b0;
`endif
    exp_err = (n > 32'h0002_0000) || csum_err;
    exp_wr.delete();
    if (n <= 32'h0002_0000)
      foreach (ws[i]) exp_wr.push_back({AW'(i), ws[i]});
    build(n, bad_csum);
    got.delete();
    send(img.size(), gaps);
    chk({tag, ".tx_valid_after_last"}, tx_valid, 1'b1);
    chk({tag, ".tx_data"}, tx_data, exp_err ? 8'hEE : 8'hAA);
`ifndef LOADER_CHECKSUM_EN
    if (!exp_err && ws.size() > 0) chk({tag, ".we_after_last"}, inst_we, 1'b1);
`endif
    repeat (hold) @(negedge clk);
    chk({tag, ".tx_held"}, {tx_valid, tx_data, core_rstn}, {1'b1, exp_err ? 8'hEE : 8'hAA, 1'b0});
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk({tag, ".tx_valid_drop"}, tx_valid, 1'b0);
    chk({tag, ".core_rstn"}, core_rstn, !exp_err);
    chk({tag, ".load_error"}, load_error, exp_err);
    chk({tag, ".wr_count"}, got.size(), exp_wr.size());
    foreach (exp_wr[i])
      if (i < got.size()) chk({tag, ".wr"}, got[i], exp_wr[i]);
  endtask

  initial begin
    int nw;
    do_reset();
    chk("rst.inst_we", inst_we, 1'b0);
    chk("rst.inst_waddr", inst_waddr, '0);
    chk("rst.inst_wdata", inst_wdata, '0);
    chk("rst.tx", {tx_valid, tx_data}, 9'd0);
    chk("rst.core_rstn", core_rstn, 1'b0);
    chk("rst.load_error", load_error, 1'b0);

    ws = '{32'h1234_5678, 32'h9ABC_DEF0};
    run_image("two_words", 32'd2, 1'b0, 1'b1, 3);
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    got.delete();
    send(8, 1'b0);
    repeat (2) @(negedge clk);
    chk("done.ignore_writes", got.size(), 0);
    chk("done.core_rstn", {core_rstn, tx_valid}, 2'b10);

    do_reset();
    ws.delete();
    run_image("len_zero", 32'd0, 1'b0, 1'b0, 0);

    do_reset();
    ws = '{32'h1111_1111, 32'h2222_2222};
    run_image("len_too_big", 32'h0002_0001, 1'b0, 1'b1, 2);
    img = '{8'hAB, 8'hCD, 8'hEF, 8'h01};
    got.delete();
    send(4, 1'b0);
    repeat (2) @(negedge clk);
    chk("err.no_writes", got.size(), 0);
    chk("err.sticky", {load_error, core_rstn, tx_valid}, 3'b100);

    do_reset();
    img = '{8'h00, 8'h02, 8'h00, 8'h00};
    send(4, 1'b0);
    repeat (2) @(negedge clk);
    chk("len_max.accepted", {load_error, tx_valid, core_rstn}, 3'b000);
    chk("len_max.no_write", got.size(), 0);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    ws = '{32'h1234_5678, 32'h9ABC_DEF0};
    run_image("bad_csum", 32'd2, 1'b1, 1'b0, 1);
`endif

    do_reset();
    ws.delete();
    for (int i = 0; i < 5; i++) ws.push_back($urandom);
    run_image("b2b_hold10", 32'd5, 1'b0, 1'b0, 10);

    do_reset();
    ws = '{32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003};
    build(32'd3, 1'b0);
    send(6, 1'b0);
    do_reset();
    ws = '{32'hDEAD_BEEF};
    run_image("reset_midload", 32'd1, 1'b0, 1'b0, 0);

    for (int r = 0; r < 3; r++) begin
      do_reset();
      ws.delete();
      nw = $urandom_range(1, 6);
      for (int i = 0; i < nw; i++) ws.push_back($urandom);
      run_image("random", 32'(nw), 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 5));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
